// File: rtl/tri_pkg.sv
// Shared types and constants for the triangle edge-setup block.
// The edge pair table gives the vertex indices (i, j) that each edge spans.
package tri_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int COORD_W   = 8;
    localparam int AB_W      = 9;
    localparam int C_W       = 17;
    localparam int NUM_VERTS = 3;
    localparam int NUM_BYTES = 2 * NUM_VERTS;

    localparam logic [1:0] EDGE_PAIR [NUM_VERTS][2] = '{
        '{2'd0, 2'd1},
        '{2'd1, 2'd2},
        '{2'd2, 2'd0}
    };

endpackage

// File: rtl/tri_loader.sv
// Byte collector: gathers x0,y0,x1,y1,x2,y2 into a shadow bank and
// raises shadow_full until the scheduler takes the triangle with swap.
module tri_loader
    import tri_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [COORD_W-1:0]                 in_data,
    input  logic                               in_valid,
    input  logic                               swap,
    output logic                               in_ready,
    output logic                               shadow_full,
    output logic [NUM_VERTS-1:0][COORD_W-1:0]  shadow_x,
    output logic [NUM_VERTS-1:0][COORD_W-1:0]  shadow_y
);

    logic [NUM_BYTES-1:0][COORD_W-1:0] bank_reg;
    logic [2:0]                        idx_reg;
    logic                              full_reg;
    logic                              accept;

    // A full bank blocks loading, so accept and swap never coincide.
    assign accept      = in_valid && !full_reg;
    assign in_ready    = !full_reg;
    assign shadow_full = full_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg  <= '0;
            full_reg <= 1'b0;
            bank_reg <= '0;
        end else begin
            if (accept) begin
                bank_reg[idx_reg] <= in_data;
                if (idx_reg == 3'(NUM_BYTES - 1)) begin
                    idx_reg  <= '0;
                    full_reg <= 1'b1;
                end else begin
                    idx_reg <= idx_reg + 3'd1;
                end
            end else if (swap) begin
                full_reg <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_VERTS; gi++) begin : g_vert
            assign shadow_x[gi] = bank_reg[2*gi];
            assign shadow_y[gi] = bank_reg[2*gi+1];
        end
    endgenerate

endmodule

// File: rtl/tri_sched.sv
// Triangle edge-setup: swaps in a loaded triangle at frame_end, computes
// A/B/C for three edges over six cycles with one multiplier, then commits.
module tri_sched
    import tri_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [COORD_W-1:0]         in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       frame_end,
    output logic                       busy,
    output logic                       params_valid,
    output logic signed [AB_W-1:0]     edge_a0,
    output logic signed [AB_W-1:0]     edge_a1,
    output logic signed [AB_W-1:0]     edge_a2,
    output logic signed [AB_W-1:0]     edge_b0,
    output logic signed [AB_W-1:0]     edge_b1,
    output logic signed [AB_W-1:0]     edge_b2,
    output logic signed [C_W-1:0]      edge_c0,
    output logic signed [C_W-1:0]      edge_c1,
    output logic signed [C_W-1:0]      edge_c2
);

    state_t state_reg, state_next;
    logic [1:0] e_reg;
    logic       phase_reg;
    logic       swap;
    logic       shadow_full;

    logic [NUM_VERTS-1:0][COORD_W-1:0] shadow_x, shadow_y;
    logic [COORD_W-1:0] x_reg [NUM_VERTS];
    logic [COORD_W-1:0] y_reg [NUM_VERTS];

    logic signed [AB_W-1:0] a_stg [NUM_VERTS];
    logic signed [AB_W-1:0] b_stg [NUM_VERTS];
    logic signed [C_W-1:0]  c_stg [NUM_VERTS];
    logic signed [AB_W-1:0] a_out [NUM_VERTS];
    logic signed [AB_W-1:0] b_out [NUM_VERTS];
    logic signed [C_W-1:0]  c_out [NUM_VERTS];
    logic                   valid_reg;

    logic [1:0]             vi, vj;
    logic [COORD_W-1:0]     mul_a, mul_b;
    logic [2*COORD_W-1:0]   product;
    logic signed [C_W-1:0]  prod_ext;
    logic signed [AB_W-1:0] a_val, b_val;

    tri_loader u_loader (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .swap        (swap),
        .in_ready    (in_ready),
        .shadow_full (shadow_full),
        .shadow_x    (shadow_x),
        .shadow_y    (shadow_y)
    );

    // A frame_end is only honoured with a complete triangle and an idle engine.
    assign swap = frame_end && shadow_full && (state_reg == IDLE);
    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (swap) state_next = MUL;
            MUL:     if (e_reg == 2'd2 && phase_reg) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Phase 0 multiplies xi*yj, phase 1 multiplies xj*yi for the same edge.
    assign vi      = EDGE_PAIR[e_reg][0];
    assign vj      = EDGE_PAIR[e_reg][1];
    assign mul_a   = phase_reg ? x_reg[vj] : x_reg[vi];
    assign mul_b   = phase_reg ? y_reg[vi] : y_reg[vj];
    assign product = mul_a * mul_b;
    assign prod_ext = $signed({1'b0, product});
    assign a_val   = $signed({1'b0, y_reg[vi]}) - $signed({1'b0, y_reg[vj]});
    assign b_val   = $signed({1'b0, x_reg[vj]}) - $signed({1'b0, x_reg[vi]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_reg     <= '0;
            phase_reg <= 1'b0;
            valid_reg <= 1'b0;
            for (int v = 0; v < NUM_VERTS; v++) begin
                x_reg[v] <= '0;
                y_reg[v] <= '0;
                a_stg[v] <= '0;
                b_stg[v] <= '0;
                c_stg[v] <= '0;
                a_out[v] <= '0;
                b_out[v] <= '0;
                c_out[v] <= '0;
            end
        end else begin
            if (swap) begin
                e_reg     <= '0;
                phase_reg <= 1'b0;
                for (int v = 0; v < NUM_VERTS; v++) begin
                    x_reg[v] <= shadow_x[v];
                    y_reg[v] <= shadow_y[v];
                end
            end
            if (state_reg == MUL) begin
                phase_reg <= ~phase_reg;
                if (phase_reg) begin
                    e_reg        <= (e_reg == 2'd2) ? 2'd0 : e_reg + 2'd1;
                    c_stg[e_reg] <= c_stg[e_reg] - prod_ext;
                end else begin
                    a_stg[e_reg] <= a_val;
                    b_stg[e_reg] <= b_val;
                    c_stg[e_reg] <= prod_ext;
                end
            end
            // All nine coefficients become visible together.
            if (state_reg == COMMIT) begin
                valid_reg <= 1'b1;
                for (int v = 0; v < NUM_VERTS; v++) begin
                    a_out[v] <= a_stg[v];
                    b_out[v] <= b_stg[v];
                    c_out[v] <= c_stg[v];
                end
            end
        end
    end

    assign params_valid = valid_reg;
    assign edge_a0 = a_out[0];
    assign edge_a1 = a_out[1];
    assign edge_a2 = a_out[2];
    assign edge_b0 = b_out[0];
    assign edge_b1 = b_out[1];
    assign edge_b2 = b_out[2];
    assign edge_c0 = c_out[0];
    assign edge_c1 = c_out[1];
    assign edge_c2 = c_out[2];

endmodule

// File: tb/tb_tri_sched.sv
// Self-checking bench for tri_sched: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_tri_sched;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         in_data = 8'd0;
    logic               in_valid = 1'b0;
    logic               frame_end = 1'b0;
    logic               in_ready, busy, params_valid;
    logic signed [8:0]  edge_a0, edge_a1, edge_a2, edge_b0, edge_b1, edge_b2;
    logic signed [16:0] edge_c0, edge_c1, edge_c2;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    tri_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .frame_end    (frame_end),
        .busy         (busy),
        .params_valid (params_valid),
        .edge_a0      (edge_a0),
        .edge_a1      (edge_a1),
        .edge_a2      (edge_a2),
        .edge_b0      (edge_b0),
        .edge_b1      (edge_b1),
        .edge_b2      (edge_b2),
        .edge_c0      (edge_c0),
        .edge_c1      (edge_c1),
        .edge_c2      (edge_c2)
    );

    always #5 clk = ~clk;

    // Behavioural model: byte list, full flag, busy countdown, committed values.
    int m_bytes [6];
    int m_work  [6];
    int m_cnt, m_full, m_busy_left, m_valid;
    int m_a [3];
    int m_b [3];
    int m_c [3];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_cnt = 0; m_full = 0; m_busy_left = 0; m_valid = 0;
        for (int k = 0; k < 6; k++) begin
            m_bytes[k] = 0;
            m_work[k]  = 0;
        end
        for (int k = 0; k < 3; k++) begin
            m_a[k] = 0; m_b[k] = 0; m_c[k] = 0;
        end
    endfunction

    function automatic void model_commit();
        int xs [3];
        int ys [3];
        for (int v = 0; v < 3; v++) begin
            xs[v] = m_work[2*v];
            ys[v] = m_work[2*v+1];
        end
        for (int e = 0; e < 3; e++) begin
            int i = e;
            int j = (e + 1) % 3;
            m_a[e] = ys[i] - ys[j];
            m_b[e] = xs[j] - xs[i];
            m_c[e] = xs[i] * ys[j] - xs[j] * ys[i];
        end
        m_valid = 1;
        $display("commit A=(%0d,%0d,%0d) B=(%0d,%0d,%0d) C=(%0d,%0d,%0d)",
                 m_a[0], m_a[1], m_a[2], m_b[0], m_b[1], m_b[2], m_c[0], m_c[1], m_c[2]);
    endfunction

    // Called once per rising edge with the inputs that edge sampled.
    function automatic void model_step();
        bit do_swap = frame_end && (m_full != 0) && (m_busy_left == 0);
        bit do_acc  = in_valid && (m_full == 0);
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) model_commit();
        end
        if (do_swap) begin
            for (int k = 0; k < 6; k++) m_work[k] = m_bytes[k];
            m_full = 0;
            m_busy_left = 7;
        end
        if (do_acc) begin
            m_bytes[m_cnt] = in_data;
            m_cnt++;
            if (m_cnt == 6) begin
                m_cnt = 0;
                m_full = 1;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", in_ready, (m_full == 0) ? 1 : 0);
            chk("busy", busy, (m_busy_left != 0) ? 1 : 0);
            chk("params_valid", params_valid, m_valid);
            chk("a0", edge_a0, m_a[0]);
            chk("a1", edge_a1, m_a[1]);
            chk("a2", edge_a2, m_a[2]);
            chk("b0", edge_b0, m_b[0]);
            chk("b1", edge_b1, m_b[1]);
            chk("b2", edge_b2, m_b[2]);
            chk("c0", edge_c0, m_c[0]);
            chk("c1", edge_c1, m_c[1]);
            chk("c2", edge_c2, m_c[2]);
        end
    end

    // One clock of stimulus; entered and left 2 time units after a rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic fe);
        in_valid  = v;
        in_data   = d;
        frame_end = fe;
        @(posedge clk);
        if (rst_n) model_step();
        #2;
        in_valid  = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic load(input int b0, input int b1, input int b2,
                        input int b3, input int b4, input int b5);
        step(1'b1, 8'(b0), 1'b0);
        step(1'b1, 8'(b1), 1'b0);
        step(1'b1, 8'(b2), 1'b0);
        step(1'b1, 8'(b3), 1'b0);
        step(1'b1, 8'(b4), 1'b0);
        step(1'b1, 8'(b5), 1'b0);
    endtask

    task automatic wait_idle(input string name, input int exp_cycles);
        int n = 0;
        while (busy && n < 20) begin
            step(1'b0, 8'd0, 1'b0);
            n++;
        end
        chk(name, n, exp_cycles);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_pv", params_valid, 0);
        chk("rst_a1", edge_a1, 0);
        chk("rst_c1", edge_c1, 0);
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 8'd0, 1'b0);
    endtask

    int px, py;

    initial begin
        model_reset();
        @(posedge clk);
        #2;
        cmp_en = 1;
        step(1'b0, 8'd0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 8'd0, 1'b0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_pv", params_valid, 0);
        chk("reset_c0", edge_c0, 0);

        // Right triangle, counter-clockwise.
        load(10, 10, 100, 10, 10, 100);
        step(1'b0, 8'd0, 1'b1);
        wait_idle("latency", 7);
        chk("s33_pv", params_valid, 1);
        chk("s33_a0", edge_a0, 0);
        chk("s33_a1", edge_a1, -90);
        chk("s33_a2", edge_a2, 90);
        chk("s33_b0", edge_b0, 90);
        chk("s33_b1", edge_b1, -90);
        chk("s33_b2", edge_b2, 0);
        chk("s33_c0", edge_c0, -900);
        chk("s33_c1", edge_c1, 9900);
        chk("s33_c2", edge_c2, -900);
        px = 20; py = 20;
        chk("pix20_e0", edge_a0 * px + edge_b0 * py + edge_c0, 900);
        chk("pix20_e1", edge_a1 * px + edge_b1 * py + edge_c1, 6300);
        chk("pix20_e2", edge_a2 * px + edge_b2 * py + edge_c2, 900);
        px = 90; py = 90;
        chk("pix90_e1", edge_a1 * px + edge_b1 * py + edge_c1, -6300);

        // Repeated frame_end with nothing loaded leaves the outputs alone.
        step(1'b0, 8'd0, 1'b1);
        chk("nofull_busy", busy, 0);
        chk("nofull_c1", edge_c1, 9900);

        // Sixth byte coincides with frame_end: no swap until the next one.
        step(1'b1, 8'd1, 1'b0);
        step(1'b1, 8'd2, 1'b0);
        step(1'b1, 8'd3, 1'b0);
        step(1'b1, 8'd4, 1'b0);
        step(1'b1, 8'd5, 1'b0);
        step(1'b1, 8'd6, 1'b1);
        chk("s35_busy", busy, 0);
        chk("s35_full", in_ready, 0);
        step(1'b0, 8'd0, 1'b1);
        chk("s35_busy2", busy, 1);
        wait_idle("s35_wait", 7);
        chk("s35_a0", edge_a0, -2);
        chk("s35_c0", edge_c0, -2);

        // Full shadow ignores further bytes.
        load(0, 0, 50, 0, 0, 50);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'hFF, 1'b0);
            chk("s36_ready", in_ready, 0);
        end
        step(1'b0, 8'd0, 1'b1);
        chk("s36_ready_after", in_ready, 1);
        wait_idle("s36_wait", 7);
        chk("s36_a1", edge_a1, -50);
        chk("s36_c1", edge_c1, 2500);
        chk("s36_b0", edge_b0, 50);

        // Reset three cycles into setup, then reload.
        load(10, 10, 100, 10, 10, 100);
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        do_reset();
        chk("s37_ready", in_ready, 1);
        load(10, 10, 100, 10, 10, 100);
        step(1'b0, 8'd0, 1'b1);
        wait_idle("s37_wait", 7);
        chk("s37_c1", edge_c1, 9900);

        // Extreme coordinates; second triangle loaded during setup.
        load(255, 0, 0, 255, 255, 255);
        step(1'b0, 8'd0, 1'b1);
        load(1, 1, 2, 2, 3, 7);
        step(1'b0, 8'd0, 1'b1);
        chk("s38_c0", edge_c0, 65025);
        chk("s38_c2", edge_c2, -65025);
        chk("s38_busy_end", busy, 0);
        step(1'b0, 8'd0, 1'b0);
        chk("s38_ignored", busy, 0);
        chk("s38_hold_c0", edge_c0, 65025);
        step(1'b0, 8'd0, 1'b1);
        wait_idle("s38_wait", 7);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic [7:0] d;
            case ($urandom_range(0, 7))
                0: d = 8'd0;
                1: d = 8'd255;
                default: d = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 6, d, $urandom_range(0, 11) == 0);
            end
        end

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tri_sched.md
TRI_SCHED -- requirements
Module: tri_sched

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have the port in_data, input, 8 bits: a vertex coordinate byte, unsigned.
REQ-004 The block SHALL have the port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: the block can accept a byte this cycle.
REQ-006 The block SHALL have the port frame_end, input, 1 bit: a 1-cycle pulse at the start of vertical blank.
REQ-007 The block SHALL have the port busy, output, 1 bit: edge setup is in progress.
REQ-008 The block SHALL have the port params_valid, output, 1 bit: the edge outputs hold a committed triangle.
REQ-009 The block SHALL have the ports edge_a0, edge_a1 and edge_a2, output, 9 bits signed each: the x coefficient of edge e.
REQ-010 The block SHALL have the ports edge_b0, edge_b1 and edge_b2, output, 9 bits signed each: the y coefficient of edge e.
REQ-011 The block SHALL have the ports edge_c0, edge_c1 and edge_c2, output, 17 bits signed each: the constant term of edge e.

Function
REQ-012 Loading: a byte SHALL be accepted on a rising edge where in_valid and in_ready are both high; bytes are taken in the order x0, y0, x1, y1, x2, y2 into a shadow bank; a 3-bit index counts 0..5 and wraps to 0 after the 6th byte.
REQ-013 The 6th accepted byte SHALL set shadow_full, and in_ready SHALL equal the inverse of shadow_full.
REQ-014 While shadow_full is high, in_valid SHALL be ignored.
REQ-015 Swap: when frame_end is sampled with shadow_full=1 and state=IDLE, the shadow bank SHALL be copied to the working vertex registers, shadow_full SHALL clear, and the state SHALL go to MUL.
REQ-016 While setup runs, loading of the next triangle into the shadow bank SHALL be permitted.
REQ-017 A frame_end with shadow_full=0, or with state other than IDLE, SHALL be ignored, with no state change.
REQ-018 A 6th byte accepted in the same cycle as frame_end SHALL NOT swap; the swap SHALL occur at the next frame_end.
REQ-019 The state machine SHALL have three states: IDLE -> MUL (6 cycles, edge counter e = 0..2, phase 0..1) -> COMMIT (1 cycle) -> IDLE.
REQ-020 Edge e SHALL use the vertex pair (i, j): e0 = (0, 1), e1 = (1, 2), e2 = (2, 0).
REQ-021 A_e SHALL equal yi - yj and B_e SHALL equal xj - xi, each 9-bit signed, computed in phase 0.
REQ-022 C_e SHALL equal xi*yj - xj*yi, 17-bit signed, using one shared 8x8 unsigned multiplier: phase 0 forms xi*yj, phase 1 subtracts xj*yi.
REQ-023 Results SHALL accumulate in staging registers; the edge_* outputs SHALL update only in COMMIT, all 9 values in the same cycle (atomic), and COMMIT SHALL set params_valid=1.
REQ-024 Latency: the edge_* outputs SHALL change on the 7th rising edge after the edge that sampled frame_end.
REQ-025 busy SHALL be high in MUL and COMMIT, and low in IDLE.
REQ-026 The edge outputs SHALL hold their values between commits; a repeated frame_end with no new triangle SHALL leave them unchanged.
REQ-027 Consumers SHALL treat a pixel (x, y) as inside the triangle when A_e*x + B_e*y + C_e >= 0 for all e (counter-clockwise winding in screen space); this block SHALL NOT check winding.

Reset
REQ-028 rst_n low SHALL asynchronously force: state=IDLE, byte index=0, shadow_full=0, in_ready=1 (after release), busy=0, params_valid=0, and all edge_*, staging, shadow and working registers=0.
REQ-029 A reset mid-load or mid-setup SHALL discard the partial data; no partial commit SHALL ever be visible.

Structure
REQ-030 A shared package tri_pkg SHALL hold: the state enum (IDLE, MUL, COMMIT), COORD_W=8, AB_W=9, C_W=17, NUM_VERTS=3, and the edge pair table.
REQ-031 There SHALL be one sub-module, tri_loader: the byte collector, index counter, shadow bank and shadow_full/in_ready logic.
REQ-032 The setup state machine and the multiplier SHALL live in tri_sched.

Verification
REQ-033 Scenario: load 10, 10, 100, 10, 10, 100, then pulse frame_end -> 7 edges later A = (0, -90, 90), B = (90, -90, 0), C = (-900, 9900, -900), params_valid=1.
REQ-034 Scenario: for the REQ-033 triangle, evaluate at (20, 20) -> edge values 900, 6300, 900 (inside); at (90, 90) -> edge 1 gives -6300 (outside).
REQ-035 Scenario: with the 6th byte landing on the frame_end cycle -> no swap, busy stays 0; the next frame_end -> commit.
REQ-036 Scenario: with shadow_full=1, hold in_valid high for 3 cycles with byte 0xFF -> the shadow is unchanged, in_ready=0; after the swap, in_ready=1 on the next cycle.
REQ-037 Scenario: drop rst_n low 3 cycles into MUL -> all outputs are 0 immediately, params_valid=0; after release, a full reload gives correct coefficients.
REQ-038 Scenario: load 255, 0, 0, 255, 255, 255 -> C0 = 65025 and C2 = -65025 with no overflow; frame_end during busy is ignored.
